// File: rtl/memory_stage_pkg.sv
// memory_stage_pkg: shared state encodings and default parameters for the MEM stage
package memory_stage_pkg;
  typedef enum logic [1:0] {
    MS_IDLE = 2'd0,
    MS_WAIT = 2'd1,
    MS_ERR  = 2'd2
  } ms_state_e;
  localparam int TIMEOUT_DEF = 64;
  localparam int CNT_W_DEF = 16;
endpackage

// File: rtl/memory_stage_reg.sv
// memory_stage_reg: plain register with synchronous active-low reset
module memory_stage_reg #(
  parameter int W = 1,
  parameter logic [W-1:0] RST_VAL = '0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  always_ff @(posedge clk) q <= rst ? d : RST_VAL;
endmodule

// File: rtl/memory_stage_timeout.sv
// mem_timeout_counter: counts cycles while enabled and flags the last allowed cycle
module mem_timeout_counter #(
  parameter int TIMEOUT = 64
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expire
);
  localparam int W = $clog2(TIMEOUT);
  logic [W-1:0] cnt_q, cnt_d;
  assign cnt_d = clr ? '0 : en ? cnt_q + 1'b1 : cnt_q;
  always_ff @(posedge clk) cnt_q <= rst ? cnt_d : '0;
  assign expire = en & (cnt_q == W'(TIMEOUT - 1));
endmodule

// File: rtl/memory_stage.sv
// memory_stage: MEM pipeline stage driving a variable-latency data memory over req/done
module memory_stage
  import memory_stage_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             valid_m,
  input  logic             memRead_m,
  input  logic             memWrite_m,
  input  logic             halt_m,
  input  logic [15:0]      aluOut_m,
  input  logic [15:0]      read2Data_m,
  output logic [15:0]      dmem_addr,
  output logic [15:0]      dmem_wdata,
  output logic             dmem_rd,
  output logic             dmem_wr,
  input  logic [15:0]      dmem_rdata,
  input  logic             dmem_done,
  input  logic             dmem_busy,
  input  logic             dmem_err,
  output logic [15:0]      memOut_m,
  output logic             stall_mem,
  output logic             err_m,
  output logic             dump_m,
  output logic [CNT_W-1:0] stallCnt
);
  logic [1:0] st_raw;
  ms_state_e state_q, state_d;
  logic err_q, err_d, halted_q, halted_d, rd_pend_q, rd_pend_d, dump_q, dump_d;
  logic [15:0] rdata_q, rdata_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic idle, wait_s, acc, bad, issue, expire, fail, rd_done, halt_fire;
  assign state_q = ms_state_e'(st_raw);
  assign idle = state_q == MS_IDLE;
  assign wait_s = state_q == MS_WAIT;
  assign acc = valid_m & (memRead_m | memWrite_m) & ~err_q & ~halted_q;
  assign bad = aluOut_m[0] | (memRead_m & memWrite_m);
  assign issue = rst & idle & acc & ~bad & ~dmem_busy;
  assign fail = ((issue | wait_s) & dmem_done & dmem_err) | (wait_s & ~dmem_done & expire) | (idle & acc & bad);
  assign rd_done = rst & dmem_done & (issue ? memRead_m : wait_s & rd_pend_q);
  assign halt_fire = valid_m & halt_m & ~stall_mem & ~halted_q;
  assign dmem_addr = aluOut_m;
  assign dmem_wdata = read2Data_m;
  memory_stage_reg #(.W(2))     u_state  (.clk(clk), .rst(rst), .d(state_d),     .q(st_raw));
  memory_stage_reg #(.W(16))    u_rdata  (.clk(clk), .rst(rst), .d(rdata_d),     .q(rdata_q));
  memory_stage_reg #(.W(1))     u_err    (.clk(clk), .rst(rst), .d(err_d),       .q(err_q));
  memory_stage_reg #(.W(1))     u_halted (.clk(clk), .rst(rst), .d(halted_d),    .q(halted_q));
  memory_stage_reg #(.W(1))     u_rdpend (.clk(clk), .rst(rst), .d(rd_pend_d),   .q(rd_pend_q));
  memory_stage_reg #(.W(1))     u_dump   (.clk(clk), .rst(rst), .d(dump_d),      .q(dump_q));
  memory_stage_reg #(.W(CNT_W)) u_scnt   (.clk(clk), .rst(rst), .d(stall_cnt_d), .q(stall_cnt_q));
  mem_timeout_counter #(.TIMEOUT(TIMEOUT)) u_tmo (
    .clk(clk),
    .rst(rst),
    .clr(~wait_s),
    .en(wait_s),
    .expire(expire)
  );
  always_comb begin
    state_d = fail ? MS_ERR : (issue & ~dmem_done) ? MS_WAIT : (wait_s & dmem_done) ? MS_IDLE : state_q;
    err_d = err_q | fail;
    rd_pend_d = issue ? memRead_m : rd_pend_q;
    rdata_d = rd_done ? dmem_rdata : rdata_q;
    halted_d = halted_q | halt_fire;
    dump_d = halt_fire;
    stall_cnt_d = (stall_mem & ~&stall_cnt_q) ? stall_cnt_q + 1'b1 : stall_cnt_q;
  end
  always_comb begin
    dmem_rd = issue & memRead_m;
    dmem_wr = issue & memWrite_m;
    stall_mem = rst & (idle ? acc & ~bad & (dmem_busy | ~dmem_done) : wait_s & ~dmem_done & ~expire);
    memOut_m = rd_done ? dmem_rdata : rdata_q;
    err_m = err_q;
    dump_m = dump_q;
    stallCnt = stall_cnt_q;
  end
endmodule
